// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential-multiplier stream adapter.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } adapter_state_e;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mult_watchdog.sv
// WAIT-phase cycle counter; expired is high on the last allowed WAIT cycle.
// Counts while enable is high, restarts on clear, no backpressure.
module mult_watchdog
  import mult_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mult_stream_adapter.sv
// Valid/ready wrapper around a start/ready sequential multiplier: start one cycle after accept,
// result held the cycle after mul_ready until out_ready. Optional WAIT abort via MULT_ADAPTER_TIMEOUT_EN.
module mult_stream_adapter
  import mult_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUMBITS-1:0]     in_a,
  input  logic [NUMBITS-1:0]     in_b,
  output logic                   mul_start,
  output logic [NUMBITS-1:0]     mul_a,
  output logic [NUMBITS-1:0]     mul_b,
  input  logic                   mul_ready,
  input  logic [2*NUMBITS-1:0]   mul_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*NUMBITS-1:0]   out_product,
  output logic                   out_err
);

  adapter_state_e state, state_nxt;

  logic                 accept;
  logic                 timed_out;
  logic [NUMBITS-1:0]   a_q, b_q;
  logic [2*NUMBITS-1:0] prod_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (mul_ready || timed_out) state_nxt = HOLD;
      end
      HOLD: begin
        // Taking a new pair while the result drains avoids an IDLE bubble.
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset) in_ready = 1'b0;
  end

  assign accept    = in_valid && in_ready;
  assign mul_start = (state == ISSUE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  assign mul_a = a_q;
  assign mul_b = b_q;

  // mul_ready has priority over a same-cycle timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
    end else if (state == WAIT) begin
      if (mul_ready) begin
        prod_q <= mul_product;
      end else if (timed_out) begin
        prod_q <= '0;
      end
    end
  end

  assign out_product = prod_q;

`ifdef MULT_ADAPTER_TIMEOUT_EN
  logic err_q;

  mult_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ISSUE),
    .enable  (state == WAIT),
    .expired (timed_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state == WAIT) begin
      if (mul_ready) begin
        err_q <= 1'b0;
      end else if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_err = err_q;
`else
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign out_err        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: doc/mult_stream_adapter.md
MULT_STREAM_ADAPTER -- requirements
Module: mult_stream_adapter

Interface
REQ-001 The block SHALL have parameter NUMBITS, default 16, operand width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before abort (used only with MULT_ADAPTER_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  input  1  clock; all flops rise-edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 The block SHALL have port in_ready  output  1  adapter accepts operand pair this cycle.
REQ-007 The block SHALL have port in_a  input  NUMBITS  signed multiplicand.
REQ-008 The block SHALL have port in_b  input  NUMBITS  signed multiplier.
REQ-009 The block SHALL have port mul_start  output  1  one-cycle start pulse to the sequential multiplier.
REQ-010 The block SHALL have port mul_a  output  NUMBITS  registered operand A to the multiplier.
REQ-011 The block SHALL have port mul_b  output  NUMBITS  registered operand B to the multiplier.
REQ-012 The block SHALL have port mul_ready  input  1  one-cycle completion pulse from the multiplier.
REQ-013 The block SHALL have port mul_product  input  2*NUMBITS  multiplier result, valid only while mul_ready=1.
REQ-014 The block SHALL have port out_valid  output  1  result held for downstream.
REQ-015 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-016 The block SHALL have port out_product  output  2*NUMBITS  registered signed product.
REQ-017 The block SHALL have port out_err  output  1  result aborted by timeout; qualified by out_valid.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, HOLD.
REQ-019 IDLE: in_ready=1; on in_valid, capture in_a/in_b into operand registers, go to ISSUE.
REQ-020 ISSUE: mul_start=1 for exactly one cycle, in_ready=0, unconditionally go to WAIT.
REQ-021 WAIT: in_ready=0, mul_start=0; on mul_ready, capture mul_product into out_product, clear out_err, go to HOLD.
REQ-022 HOLD: out_valid=1, out_product/out_err stable; in_ready=out_ready.
REQ-023 HOLD with out_ready=1 and in_valid=1 SHALL capture new operands and go to ISSUE (no IDLE bubble).
REQ-024 HOLD with out_ready=1 and in_valid=0 SHALL go to IDLE; out_ready=0 SHALL stay in HOLD indefinitely.
REQ-025 mul_a/mul_b SHALL change only on an accepted input handshake; stable from ISSUE through end of WAIT.
REQ-026 mul_ready outside WAIT SHALL be ignored; no state or data change.
REQ-027 Latency SHALL be: accept at cycle N, mul_start at N+1, out_valid the cycle after mul_ready.
REQ-028 out_product SHALL be an exact copy of mul_product; no width change, rounding or sign handling.

Reset
REQ-029 Reset low SHALL immediately force state IDLE; in_ready, mul_start, out_valid and out_err to 0, operand registers and out_product to 0, timeout counter to 0.
REQ-030 Reset asserted during WAIT SHALL abandon the transaction; a later mul_ready SHALL be ignored per REQ-026.
REQ-031 After reset release in IDLE, in_ready SHALL be 1.

Configuration
REQ-032 With macro MULT_ADAPTER_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle; if it reaches TIMEOUT-1 without mul_ready, go to HOLD with out_err=1 and out_product=0.
REQ-033 With MULT_ADAPTER_TIMEOUT_EN, mul_ready in the same cycle as the timeout SHALL win (normal result, out_err=0).
REQ-034 Without MULT_ADAPTER_TIMEOUT_EN, WAIT SHALL last until mul_ready, no counter SHALL exist, and out_err SHALL be constant 0.

Structure
REQ-035 Package mult_pkg SHALL hold typedef adapter_state_e (IDLE, ISSUE, WAIT, HOLD) and constant DEFAULT_TIMEOUT=64.
REQ-036 The timeout counter SHALL be sub-module mult_watchdog (inputs clk, reset, clear, enable; output expired), instantiated only under MULT_ADAPTER_TIMEOUT_EN.

Verification
REQ-037 NUMBITS=8, in_a=0xFD, in_b=0x05, model mul_ready after 9 cycles with 0xFFF1 -> out_valid=1, out_product=0xFFF1, out_err=0.
REQ-038 Two pairs back-to-back with out_ready=1 in HOLD -> second mul_start exactly one cycle after the first result handshake, no IDLE cycle.
REQ-039 out_ready=0 for 20 cycles in HOLD with in_valid=1 -> in_ready=0, out_product stable, no mul_start.
REQ-040 Macro defined, TIMEOUT=16, no mul_ready -> HOLD entered 16 cycles after WAIT entry, out_err=1, out_product=0.
REQ-041 Reset pulsed mid-WAIT, then mul_ready pulsed -> in IDLE, out_valid=0, product not captured.
REQ-042 Spurious mul_ready pulse in IDLE -> no state change, out_valid stays 0.
